// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter that time-shares the 8-bit bidirectional uio bus between
// N_REQ requesters, running one-beat read or write transfers with turnaround.
module uio_bus_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int TURN_CYCLES = 1,
  localparam int IDW         = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_write,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [7:0]         rsp_data,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic               busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_TURN} state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q;
  logic           wr_q;
  logic [3:0]     turn_cnt_q;
  logic [7:0]     uio_out_q, uio_oe_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [7:0]     rsp_data_q;

  logic           found;
  logic           grant_valid;
  logic [IDW-1:0] win_id;
  logic           win_write;
  logic [7:0]     win_data;
  logic [N_REQ-1:0] grant_oh;
  logic [IDW:0]   scan_sum;
  logic [IDW:0]   next_sum;

  // Scan from ptr upward, wrapping modulo N_REQ; the first pending request wins.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    found     = 1'b0;
    win_id    = '0;
    scan_sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(N_REQ)) scan_sum = scan_sum - (IDW+1)'(N_REQ);
      if (!found && req_valid[scan_sum[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = scan_sum[IDW-1:0];
      end
    end

    grant_valid = (state_q == ST_IDLE) && ena && found;
    grant_oh    = '0;
    win_write   = 1'b0;
    win_data    = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_valid && (win_id == IDW'(i))) begin
        grant_oh[i] = 1'b1;
        win_write   = req_write[i];
        win_data    = req_data[8*i +: 8];
      end
    end

    next_sum = {1'b0, win_id} + (IDW+1)'(1);
    if (next_sum == (IDW+1)'(N_REQ)) next_sum = '0;
    ptr_d = next_sum[IDW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      turn_cnt_q  <= '0;
      uio_out_q   <= 8'h00;
      uio_oe_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q   <= ST_XFER;
            ptr_q     <= ptr_d;
            // NOTE: id_q/wr_q are only read in XFER after being loaded here,
            // so they carry no reset.
            id_q      <= win_id;
            wr_q      <= win_write;
            uio_oe_q  <= {8{win_write}};
            uio_out_q <= win_write ? win_data : 8'h00;
          end
        end
        ST_XFER: begin
          uio_oe_q  <= 8'h00;
          uio_out_q <= 8'h00;
          if (wr_q) begin
            state_q    <= ST_TURN;
            turn_cnt_q <= 4'(TURN_CYCLES - 1);
          end else begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= uio_in;
          end
        end
        ST_TURN: begin
          if (turn_cnt_q == 4'd0) state_q <= ST_IDLE;
          else                    turn_cnt_q <= turn_cnt_q - 4'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = grant_oh;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign uio_out   = uio_out_q;
  assign uio_oe    = uio_oe_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: read responses are predicted into a
// scoreboard queue at stimulus time and compared when rsp_valid fires.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [3:0]  req_valid, req_write, req_ready;
  logic [31:0] req_data;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data, uio_in, uio_out, uio_oe;

  logic [3:0]  req_valid3, req_write3, req_ready3;
  logic [31:0] req_data3;
  logic        rsp_valid3, busy3;
  logic [1:0]  rsp_id3;
  logic [7:0]  rsp_data3, uio_in3, uio_out3, uio_oe3;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed { logic [1:0] id; logic [7:0] data; } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  uio_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid), .req_write(req_write), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .busy(busy)
  );

  uio_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ena(ena),
    .req_valid(req_valid3), .req_write(req_write3), .req_data(req_data3),
    .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_id(rsp_id3),
    .rsp_data(rsp_data3), .uio_in(uio_in3), .uio_out(uio_out3),
    .uio_oe(uio_oe3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
    rsp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer for the main instance.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    int         rr_order [6];
    logic [3:0] exp_oh;
    rr_order = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1; ena = 1'b1;
    req_valid = '0; req_write = '0; req_data = '0; uio_in = '0;
    req_valid3 = '0; req_write3 = '0; req_data3 = '0; uio_in3 = '0;
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_oe", 32'(uio_oe), 32'd0);
    check("rst_out", 32'(uio_out), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    cyc();

    // Round-robin: four continuous readers, a grant every other cycle
    req_valid = 4'hF; req_write = 4'h0;
    for (int k = 0; k < 12; k++) begin
      uio_in = 8'h40 + 8'(k);
      @(negedge clk);
      if (k % 2 == 0) begin
        exp_oh = 4'b0001 << rr_order[k/2];
        check("rr_grant", 32'(req_ready), 32'(exp_oh));
        push_exp(2'(rr_order[k/2]), 8'h40 + 8'(k + 1));
      end else begin
        check("rr_gap", 32'(req_ready), 32'd0);
      end
      cyc();
    end
    req_valid = 4'h0;

    // Single write from requester 1
    req_valid = 4'b0010; req_write = 4'b0010; req_data = 32'h0000_A500;
    @(negedge clk);
    check("wr_ready", 32'(req_ready), 32'b0010);
    check("wr_busy_t", 32'(busy), 32'd0);
    cyc(); req_valid = '0; req_write = '0;
    @(negedge clk);
    check("wr_xfer_oe", 32'(uio_oe), 32'hFF);
    check("wr_xfer_out", 32'(uio_out), 32'hA5);
    check("wr_xfer_busy", 32'(busy), 32'd1);
    cyc();
    @(negedge clk);
    check("wr_turn_oe", 32'(uio_oe), 32'h00);
    check("wr_turn_out", 32'(uio_out), 32'h00);
    check("wr_turn_busy", 32'(busy), 32'd1);
    cyc();
    @(negedge clk);
    check("wr_idle_busy", 32'(busy), 32'd0);
    cyc();

    // Single read from requester 2
    req_valid = 4'b0100; uio_in = 8'hFF;
    @(negedge clk);
    check("rd_ready", 32'(req_ready), 32'b0100);
    check("rd_oe_t", 32'(uio_oe), 32'h00);
    cyc(); req_valid = '0; uio_in = 8'h3C; push_exp(2'd2, 8'h3C);
    @(negedge clk);
    check("rd_oe_xfer", 32'(uio_oe), 32'h00);
    check("rd_rsp_early", 32'(rsp_valid), 32'd0);
    cyc(); uio_in = 8'h00;
    @(negedge clk);
    check("rd_rsp_t2", 32'(rsp_valid), 32'd1);
    check("rd_oe_t2", 32'(uio_oe), 32'h00);
    cyc();

    // Pointer persistence: grant 3, then 0 and 2 compete
    req_valid = 4'b1000; uio_in = 8'h77;
    @(negedge clk);
    check("pp_g3", 32'(req_ready), 32'b1000);
    cyc(); req_valid = '0; push_exp(2'd3, 8'h77);
    @(negedge clk);
    cyc();
    req_valid = 4'b0101; uio_in = 8'h5A;
    @(negedge clk);
    check("pp_g0", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'b0100; push_exp(2'd0, 8'h5A);
    @(negedge clk);
    check("pp_xfer", 32'(req_ready), 32'd0);
    cyc(); uio_in = 8'h6B;
    @(negedge clk);
    check("pp_g2", 32'(req_ready), 32'b0100);
    cyc(); req_valid = '0; push_exp(2'd2, 8'h6B);
    repeat (2) begin
      @(negedge clk);
      cyc();
    end

    // Reset during a write XFER
    req_valid = 4'b0010; req_write = 4'b0010; req_data = 32'h0000_C300;
    @(negedge clk);
    check("rs_grant", 32'(req_ready), 32'b0010);
    cyc(); req_valid = '0; req_write = '0; rst = 1'b1;
    @(negedge clk);
    check("rs_xfer_oe", 32'(uio_oe), 32'hFF);
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("rs_oe", 32'(uio_oe), 32'h00);
    check("rs_out", 32'(uio_out), 32'h00);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_rsp", 32'(rsp_valid), 32'd0);
    cyc();

    // ena low blocks grants; raising it grants in the same cycle
    ena = 1'b0; req_valid = 4'hF; req_write = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ena_off_ready", 32'(req_ready), 32'd0);
      check("ena_off_busy", 32'(busy), 32'd0);
      cyc();
    end
    ena = 1'b1; uio_in = 8'h99;
    @(negedge clk);
    check("ena_on_ready", 32'(req_ready), 32'b0001);
    cyc(); req_valid = '0; push_exp(2'd0, 8'h99);
    repeat (2) begin
      @(negedge clk);
      cyc();
    end

    // Turnaround length on the TURN_CYCLES=3 instance
    req_valid3 = 4'b0011; req_write3 = 4'b0001; req_data3 = 32'h0000_00E7;
    @(negedge clk);
    check("ta_wgrant", 32'(req_ready3), 32'b0001);
    cyc(); req_valid3 = 4'b0010; req_write3 = 4'b0000; uio_in3 = 8'h2D;
    @(negedge clk);
    check("ta_xfer_oe", 32'(uio_oe3), 32'hFF);
    check("ta_xfer_out", 32'(uio_out3), 32'hE7);
    check("ta_xfer_ready", 32'(req_ready3), 32'd0);
    cyc();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("ta_turn_oe", 32'(uio_oe3), 32'h00);
      check("ta_turn_ready", 32'(req_ready3), 32'd0);
      check("ta_turn_busy", 32'(busy3), 32'd1);
      cyc();
    end
    @(negedge clk);
    check("ta_rgrant", 32'(req_ready3), 32'b0010);
    cyc(); req_valid3 = '0;
    @(negedge clk);
    check("ta_rd_oe", 32'(uio_oe3), 32'h00);
    cyc();
    @(negedge clk);
    check("ta_rsp_valid", 32'(rsp_valid3), 32'd1);
    check("ta_rsp_id", 32'(rsp_id3), 32'd1);
    check("ta_rsp_data", 32'(rsp_data3), 32'h2D);
    cyc();

    repeat (2) cyc();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
